// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and helpers for the instruction-fetch responder.
// Holds the FSM encoding and the big-endian byte-lane insert helper.
package inst_fetch_resp_pkg;

    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_RD   = 1'b1
    } fetch_st_t;

    localparam logic [31:0] ZERO_WORD = 32'h0;

    // Beat 0 is the most significant byte of the instruction word.
    function automatic logic [31:0] put_byte(
        input logic [31:0] w,
        input logic [1:0]  cnt,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        unique case (cnt)
            2'd0: r[31:24] = b;
            2'd1: r[23:16] = b;
            2'd2: r[15:8]  = b;
            2'd3: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: one-word buffer in front of a byte-wide memory.
// Ports: clk/rst, CPU side rom_ce_i/rom_addr_i/rom_data_o/stallreq_o/flush_i, memory side mem_*.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              stallreq_o,
    input  logic              flush_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    input  logic              mem_ack_i
);

    fetch_st_t   state;
    logic        buf_valid;
    logic [29:0] buf_tag;
    logic [31:0] buf_data;
    logic [29:0] f_addr;
    logic [1:0]  cnt;
    logic        discard;
    logic [31:0] asm_word;

    logic        hit;
    logic [31:0] next_word;
    logic        unused_bits;

    assign unused_bits = ^rom_addr_i[1:0];
    assign hit         = buf_valid && (buf_tag == rom_addr_i[31:2]);
    assign next_word   = put_byte(asm_word, cnt, mem_data_i);

    // Reset also masks the CPU-side outputs so the pipeline sees no stall.
    always_comb begin
        rom_data_o = ZERO_WORD;
        stallreq_o = 1'b0;
        if (rst && rom_ce_i) begin
            if (hit) begin
                rom_data_o = buf_data;
            end else begin
                stallreq_o = 1'b1;
            end
        end
        mem_rd_o   = (state == FETCH_RD);
        mem_addr_o = '0;
        if (state == FETCH_RD) begin
            mem_addr_o = {f_addr[ADDR_W-3:0], cnt};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FETCH_IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= ZERO_WORD;
            f_addr    <= '0;
            cnt       <= 2'd0;
            discard   <= 1'b0;
            asm_word  <= ZERO_WORD;
        end else begin
            unique case (state)
                FETCH_IDLE: begin
                    if (flush_i) begin
                        buf_valid <= 1'b0;
                    end
                    if (rom_ce_i && !hit) begin
                        f_addr  <= rom_addr_i[31:2];
                        cnt     <= 2'd0;
                        discard <= 1'b0;
                        state   <= FETCH_RD;
                    end
                end
                FETCH_RD: begin
                    // Flushed fetches still finish so the memory
                    // handshake is never cut mid-beat.
                    if (flush_i) begin
                        discard   <= 1'b1;
                        buf_valid <= 1'b0;
                    end
                    if (mem_ack_i) begin
                        asm_word <= next_word;
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            buf_data  <= next_word;
                            buf_tag   <= f_addr;
                            buf_valid <= !discard && !flush_i;
                            state     <= FETCH_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp with a byte memory model.
// Stimulus pushes expected word and stall length; a monitor pops on accept.
module tb_inst_fetch_resp;

    localparam int ADDR_W = 20;

    logic              clk;
    logic              rst;
    logic              rom_ce_i;
    logic [31:0]       rom_addr_i;
    logic [31:0]       rom_data_o;
    logic              stallreq_o;
    logic              flush_i;
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_i;
    logic              mem_ack_i;

    inst_fetch_resp #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .stallreq_o (stallreq_o),
        .flush_i    (flush_i),
        .mem_rd_o   (mem_rd_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          stall;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int issued = 0;
    int done   = 0;
    int stall_ctr = 0;
    bit mon_en = 0;
    exp_t sb[$];
    logic [ADDR_W-1:0] alog[$];

    logic [7:0] mem [4096];
    int lat = 0;
    int wctr = 0;

    assign mem_ack_i  = mem_rd_o && (wctr >= lat);
    assign mem_data_i = mem_ack_i ? mem[mem_addr_o[11:0]] : 8'h00;

    always @(posedge clk) begin
        if (!mem_rd_o || mem_ack_i) wctr <= 0;
        else wctr <= wctr + 1;
    end

    always @(negedge clk) begin
        if (mem_rd_o && mem_ack_i) alog.push_back(mem_addr_o);
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {mem[b], mem[b + 12'd1], mem[b + 12'd2], mem[b + 12'd3]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!mon_en || !rst) begin
            stall_ctr = 0;
        end else if (rom_ce_i) begin
            if (stallreq_o) begin
                stall_ctr++;
            end else begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept got %h addr %h",
                             rom_data_o, rom_addr_i);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (rom_data_o !== e.word) begin
                        errors++;
                        $display("FAIL word addr %h got %h want %h",
                                 rom_addr_i, rom_data_o, e.word);
                    end
                    checks++;
                    if (stall_ctr != e.stall) begin
                        errors++;
                        $display("FAIL stall_len addr %h got %0d want %0d",
                                 rom_addr_i, stall_ctr, e.stall);
                    end
                end
                stall_ctr = 0;
                done++;
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input int st);
        exp_t e;
        e.word  = word_at(a);
        e.stall = st;
        sb.push_back(e);
        issued++;
    endtask

    // Entered and left at posedge+1.
    task automatic wait_done();
        int n;
        n = 0;
        while (done != issued) begin
            @(posedge clk);
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL timeout addr %h done %0d issued %0d",
                         rom_addr_i, done, issued);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input int st);
        rom_ce_i   = 1'b1;
        rom_addr_i = a;
        push_exp(a, st);
        wait_done();
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        bit          mv;
        logic [29:0] mtag;
        logic [31:0] a;
        int          st;
        logic [ADDR_W-1:0] ea;

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h20;

        rst = 1'b0; rom_ce_i = 1'b1; rom_addr_i = 32'h0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("rst_data", rom_data_o, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;
        alog.delete();

        lat = 0;
        issue(32'h0, 5);
        chk("word0_const", word_at(32'h0), 32'h34010020);
        issue(32'h2, 0);
        issue(32'h4, 5);
        chk("alog_size", 32'(alog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            ea = ADDR_W'(i);
            if (i < alog.size()) chk("alog_addr", 32'(alog[i]), 32'(ea));
        end

        lat = 1;
        issue(32'h100, 9);

        lat = 0;
        rom_ce_i = 1'b1;
        rom_addr_i = 32'h200;
        push_exp(32'h200, 10);
        @(posedge clk);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        wait_done();

        mon_en = 1'b0;
        rom_addr_i = 32'h300;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_mem_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("rst_mid_stall", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        issue(32'h200, 5);
        issue(32'h300, 5);

        rom_ce_i = 1'b0;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        mv = 0;
        mtag = '0;

        for (int k = 0; k < 80; k++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op == 0) begin
                rom_ce_i = 1'b0;
                flush_i = 1'b1;
                @(posedge clk); #1;
                flush_i = 1'b0;
                mv = 0;
            end else if (op == 1) begin
                rom_ce_i = 1'b0;
                rom_addr_i = $urandom;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end else begin
                lat = $urandom_range(0, 2);
                a = 32'h400 + 32'($urandom_range(0, 7) * 4)
                    + 32'($urandom_range(0, 3));
                if (mv && mtag == a[31:2]) st = 0;
                else st = 1 + 4 * (lat + 1);
                mv = 1;
                mtag = a[31:2];
                issue(a, st);
            end
        end

        rom_ce_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
